count_game_top: RTL and testbench

Top level of the dot-counting game. Each round a pseudo-random number of dots (1..64) is lit on the 8x8 bi-colour matrix. The player enters the count in binary on `sw[6:0]` and presses `start` to submit. The block scores the answer, gives red/green/beep feedback, and shows score, round and the current entry on the 8-digit 7-segment display. It is the board-level top: it directly drives the LEDs, the 7-segment display, the matrix and the buzzer.

---
 rtl/count_game_top.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_count_game_top.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_game_top.sv
// Dot-counting game board top: random dot count on the 8x8 matrix, binary answer on the
// switches, scored with red/green/beep feedback and shown on the scanned 7-segment display.
module count_game_top #(
    parameter int SCAN_DIV      = 1000,
    parameter int RESULT_CYCLES = 25_000_000,
    parameter int ROUNDS        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  sw,
    output logic [15:0] led,
    output logic [7:0]  seg,
    output logic [7:0]  dig,
    output logic [7:0]  row,
    output logic [7:0]  colg,
    output logic [7:0]  colr,
    output logic        beep
);

    localparam int RW = $clog2(RESULT_CYCLES + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        RESULT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            start_meta_r;
    logic            start_sync_r;
    logic            start_prev_r;
    logic            press_r;
    logic [7:0]      lfsr_r;
    logic [6:0]      target_r;
    logic            correct_r;
    logic [RW-1:0]   result_cnt_r;
    logic [3:0]      score_r;
    logic [3:0]      round_r;
    logic [SW-1:0]   scan_cnt_r;
    logic [2:0]      scan_idx_r;
    logic            result_done_s;
    logic            load_target_s;
    logic            clear_game_s;

    logic [15:0]     led_r;
    logic [7:0]      seg_r;
    logic [7:0]      dig_r;
    logic [7:0]      row_r;
    logic [7:0]      colg_r;
    logic [7:0]      colr_r;
    logic            beep_r;

    logic [15:0]     led_s;
    logic [7:0]      seg_s;
    logic [7:0]      dig_s;
    logic [7:0]      row_s;
    logic [7:0]      colg_s;
    logic [7:0]      colr_s;
    logic            beep_s;
    logic [7:0]      sel_s;
    logic [7:0]      therm_s;
    logic [3:0]      digit_val_s;
    logic            digit_blank_s;
    logic [7:0]      digit_seg_s;

    // Bit c is set when cell r*8+c lies below n: the row slice of an n-cell fill.
    function automatic logic [7:0] row_fill(input logic [2:0] r, input logic [6:0] n);
        logic [7:0] f;
        f = 8'h00;
        for (int c = 0; c < 8; c++) begin
            f[c] = ({1'b0, r, 3'(c)} < n);
        end
        return f;
    endfunction

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    assign result_done_s = (state_r == RESULT) && (result_cnt_r == RW'(RESULT_CYCLES - 1));
    assign load_target_s = (next_state_s == SHOW) && (state_r != SHOW);
    assign clear_game_s  = (next_state_s == IDLE) || ((state_r == DONE) && (next_state_s == SHOW));

    // Start button synchroniser and rising-edge detector producing a one-clock press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_meta_r <= 1'b0;
            start_sync_r <= 1'b0;
            start_prev_r <= 1'b0;
            press_r      <= 1'b0;
        end else begin
            start_meta_r <= start;
            start_sync_r <= start_meta_r;
            start_prev_r <= start_sync_r;
            press_r      <= start_sync_r & ~start_prev_r;
        end
    end

    // Free-running Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a dropped enable wins over everything else.
    always_comb begin
        next_state_s = state_r;
        if (!sw[7]) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: next_state_s = SHOW;
                SHOW: begin
                    if (press_r) next_state_s = RESULT;
                    else         next_state_s = SHOW;
                end
                RESULT: begin
                    if (!result_done_s)                    next_state_s = RESULT;
                    else if (round_r + 4'd1 == 4'(ROUNDS)) next_state_s = DONE;
                    else                                   next_state_s = SHOW;
                end
                DONE: begin
                    if (press_r) next_state_s = SHOW;
                    else         next_state_s = DONE;
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Game datapath: target latch, verdict, RESULT timer, score and round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_r     <= 7'd0;
            correct_r    <= 1'b0;
            result_cnt_r <= '0;
            score_r      <= 4'd0;
            round_r      <= 4'd0;
        end else begin
            if (load_target_s) begin
                target_r <= {1'b0, lfsr_r[5:0]} + 7'd1;
            end
            if ((state_r == SHOW) && (next_state_s == RESULT)) begin
                correct_r    <= (sw[6:0] == target_r);
                result_cnt_r <= '0;
            end else if (state_r == RESULT) begin
                result_cnt_r <= result_cnt_r + RW'(1);
            end
            if (clear_game_s) begin
                score_r <= 4'd0;
                round_r <= 4'd0;
            end else if (result_done_s) begin
                score_r <= score_r + {3'd0, correct_r};
                round_r <= round_r + 4'd1;
            end
        end
    end

    // Shared scan timer for matrix rows and display digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r <= '0;
            scan_idx_r <= 3'd0;
        end else if (scan_cnt_r == SW'(SCAN_DIV - 1)) begin
            scan_cnt_r <= '0;
            scan_idx_r <= scan_idx_r + 3'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SW'(1);
        end
    end

    // Value and blanking of the digit currently being scanned.
    always_comb begin
        digit_val_s   = 4'd0;
        digit_blank_s = 1'b0;
        case (scan_idx_r)
            3'd0: digit_val_s = 4'(score_r % 4'd10);
            3'd1: digit_val_s = 4'(score_r / 4'd10);
            3'd3: begin
                if (state_r == DONE) digit_val_s = 4'(ROUNDS);
                else                 digit_val_s = round_r + 4'd1;
            end
            3'd4: digit_val_s = 4'(sw[6:0] % 7'd10);
            3'd5: digit_val_s = 4'((sw[6:0] / 7'd10) % 7'd10);
            3'd6: digit_val_s = 4'(sw[6:0] / 7'd100);
            default: digit_blank_s = 1'b1;
        endcase
    end

    assign digit_seg_s = digit_blank_s ? 8'h00 : seg_encode(digit_val_s);
    assign sel_s       = ~(8'd1 << scan_idx_r);

    // Completed-round thermometer for the upper LEDs.
    always_comb begin
        therm_s = 8'h00;
        for (int k = 0; k < 8; k++) begin
            therm_s[k] = (4'(k) < round_r);
        end
    end

    // Output decode from state and scan position, registered below.
    always_comb begin
        led_s  = {therm_s, sw};
        row_s  = 8'hFF;
        dig_s  = 8'hFF;
        seg_s  = 8'h00;
        colg_s = 8'h00;
        colr_s = 8'h00;
        beep_s = 1'b0;
        case (state_r)
            IDLE: begin
                row_s = 8'hFF;
            end
            SHOW: begin
                row_s  = sel_s;
                dig_s  = sel_s;
                seg_s  = digit_seg_s;
                colg_s = row_fill(scan_idx_r, target_r);
            end
            RESULT: begin
                row_s = sel_s;
                dig_s = sel_s;
                seg_s = digit_seg_s;
                if (correct_r) begin
                    colg_s = 8'hFF;
                end else begin
                    colr_s = 8'hFF;
                    beep_s = 1'b1;
                end
            end
            DONE: begin
                row_s  = sel_s;
                dig_s  = sel_s;
                seg_s  = digit_seg_s;
                colg_s = row_fill(scan_idx_r, {3'd0, score_r});
            end
            default: row_s = 8'hFF;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r  <= 16'h0000;
            seg_r  <= 8'h00;
            dig_r  <= 8'hFF;
            row_r  <= 8'hFF;
            colg_r <= 8'h00;
            colr_r <= 8'h00;
            beep_r <= 1'b0;
        end else begin
            led_r  <= led_s;
            seg_r  <= seg_s;
            dig_r  <= dig_s;
            row_r  <= row_s;
            colg_r <= colg_s;
            colr_r <= colr_s;
            beep_r <= beep_s;
        end
    end

    assign led  = led_r;
    assign seg  = seg_r;
    assign dig  = dig_r;
    assign row  = row_r;
    assign colg = colg_r;
    assign colr = colr_r;
    assign beep = beep_r;

endmodule

// File: tb/tb_count_game_top.sv
// Directed bench for count_game_top with short scan/result timing and a 3-round game.
module tb_count_game_top;

    localparam int SCAN_DIV      = 2;
    localparam int RESULT_CYCLES = 100;
    localparam int ROUNDS        = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [7:0]  seg;
    logic [7:0]  dig;
    logic [7:0]  row;
    logic [7:0]  colg;
    logic [7:0]  colr;
    logic        beep;

    int n_tests = 0;
    int n_fail  = 0;
    int beep_total = 0;

    logic [7:0] fr_colg [8];
    logic [7:0] fr_colr [8];
    logic [7:0] fr_seg  [8];
    logic [7:0] fr_seen;

    count_game_top #(
        .SCAN_DIV(SCAN_DIV),
        .RESULT_CYCLES(RESULT_CYCLES),
        .ROUNDS(ROUNDS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sw(sw), .led(led), .seg(seg),
        .dig(dig), .row(row), .colg(colg), .colr(colr), .beep(beep)
    );

    always #5 clk = ~clk;

    // Running count of clocks with the buzzer on.
    always @(negedge clk) begin
        if (beep) beep_total++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg_ref(input int d);
        case (d)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full scan frame; returns the number of lit green cells.
    task automatic capture_frame(output int lit);
        logic [7:0] sel;
        lit = 0;
        fr_seen = 8'h00;
        for (int i = 0; i < 8; i++) begin
            fr_colg[i] = 8'h00;
            fr_colr[i] = 8'h00;
            fr_seg[i]  = 8'h00;
        end
        repeat (8 * SCAN_DIV) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                sel = ~(8'd1 << i);
                if (row == sel) begin
                    fr_colg[i] = colg;
                    fr_colr[i] = colr;
                    fr_seen[i] = 1'b1;
                end
                if (dig == sel) fr_seg[i] = seg;
            end
        end
        for (int i = 0; i < 8; i++) lit += $countones(fr_colg[i]);
    endtask

    // Checks a SHOW frame: count in range, prefix-shaped fill, no red.
    task automatic check_show(input string tag, output int n);
        logic [7:0] expf;
        bit shape_ok;
        logic [7:0] r_or;
        capture_frame(n);
        check_val({tag, "_range"}, (n >= 1 && n <= 64), 1);
        shape_ok = 1'b1;
        r_or = 8'h00;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) expf[c] = ((r * 8 + c) < n);
            if (fr_colg[r] !== expf) shape_ok = 1'b0;
            r_or |= fr_colr[r];
        end
        check_val({tag, "_shape"}, shape_ok, 1);
        check_val({tag, "_rows"}, fr_seen, 8'hFF);
        check_val({tag, "_colr"}, r_or, 8'h00);
    endtask

    task automatic press_start();
        start = 1'b1;
        wait_clk(10);
        start = 1'b0;
        wait_clk(5);
    endtask

    initial begin
        int n1, n2, nk, lit, b0, exp_score;
        logic [7:0] g_and, g_or, r_and, r_or;

        rst = 1'b1; start = 1'b0; sw = 8'h00;
        wait_clk(3);
        check_val("rst_led", led, 16'h0000);
        check_val("rst_seg", seg, 8'h00);
        check_val("rst_dig", dig, 8'hFF);
        check_val("rst_row", row, 8'hFF);
        check_val("rst_colg", colg, 8'h00);
        check_val("rst_colr", colr, 8'h00);
        check_val("rst_beep", beep, 1'b0);

        rst = 1'b0; sw = 8'h2B;
        wait_clk(4);
        check_val("idle_row", row, 8'hFF);
        check_val("idle_dig", dig, 8'hFF);
        check_val("idle_beep", beep, 1'b0);
        check_val("idle_led", led, 16'h002B);

        // Round 1: answer correctly
        sw = 8'h80;
        wait_clk(4);
        check_show("show1", n1);
        check_val("show1_d0", fr_seg[0], 8'h3F);
        check_val("show1_d1", fr_seg[1], 8'h3F);
        check_val("show1_d2", fr_seg[2], 8'h00);
        check_val("show1_d3", fr_seg[3], 8'h06);
        check_val("show1_d4", fr_seg[4], 8'h3F);
        check_val("show1_d7", fr_seg[7], 8'h00);
        sw = 8'h80 | 8'(n1);
        b0 = beep_total;
        press_start();
        press_start();
        capture_frame(lit);
        g_and = 8'hFF; r_or = 8'h00;
        for (int r = 0; r < 8; r++) begin g_and &= fr_colg[r]; r_or |= fr_colr[r]; end
        check_val("ok_colg", g_and, 8'hFF);
        check_val("ok_colr", r_or, 8'h00);
        wait_clk(100);
        check_val("ok_beep_cnt", beep_total - b0, 0);

        // Round 2: answer wrongly
        check_show("show2", n2);
        check_val("show2_score", fr_seg[0], 8'h06);
        check_val("show2_round", fr_seg[3], 8'h5B);
        check_val("show2_led", led[15:8], 8'h01);
        sw = 8'h80 | 8'(n2 + 1);
        b0 = beep_total;
        press_start();
        capture_frame(lit);
        g_or = 8'h00; r_and = 8'hFF;
        for (int r = 0; r < 8; r++) begin g_or |= fr_colg[r]; r_and &= fr_colr[r]; end
        check_val("bad_colg", g_or, 8'h00);
        check_val("bad_colr", r_and, 8'hFF);
        wait_clk(100);
        check_val("bad_beep_cnt", beep_total - b0, 100);
        capture_frame(lit);
        check_val("bad_score", fr_seg[0], 8'h06);
        check_val("bad_round", fr_seg[3], 8'h4F);
        check_val("bad_led", led[15:8], 8'h03);

        // Enable drop clears the game
        sw = 8'h00;
        wait_clk(3);
        check_val("drop_led", led, 16'h0000);
        check_val("drop_dig", dig, 8'hFF);

        // Fresh game answering 43 three times
        sw = 8'hAB;
        wait_clk(3);
        exp_score = 0;
        for (int k = 0; k < 3; k++) begin
            capture_frame(nk);
            if (nk == 43) exp_score++;
            press_start();
            wait_clk(2500 - 15 - 8 * SCAN_DIV);
        end
        capture_frame(lit);
        check_val("done_lit", lit, exp_score);
        check_val("done_led", led[15:8], 8'h07);
        check_val("done_d0", fr_seg[0], seg_ref(exp_score));
        check_val("done_d3", fr_seg[3], 8'h4F);
        check_val("done_d4", fr_seg[4], 8'h4F);
        check_val("done_d5", fr_seg[5], 8'h66);
        check_val("done_d6", fr_seg[6], 8'h3F);

        // Restart from DONE
        press_start();
        check_show("restart", nk);
        check_val("restart_score", fr_seg[0], 8'h3F);
        check_val("restart_round", fr_seg[3], 8'h06);
        check_val("restart_led", led[15:8], 8'h00);

        // Reset in the middle of a wrong RESULT
        sw = 8'h80;
        press_start();
        wait_clk(5);
        check_val("mid_beep", beep, 1'b1);
        rst = 1'b1;
        #1;
        check_val("arst_led", led, 16'h0000);
        check_val("arst_seg", seg, 8'h00);
        check_val("arst_dig", dig, 8'hFF);
        check_val("arst_row", row, 8'hFF);
        check_val("arst_colg", colg, 8'h00);
        check_val("arst_colr", colr, 8'h00);
        check_val("arst_beep", beep, 1'b0);
        wait_clk(2);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
